// File: rtl/toysram_pkg.sv
// Shared geometry, FSM encoding and request bundle for the 16x12 2R1W subarray sequencer.
package toysram_pkg;

    localparam int ROWS   = 16;
    localparam int COLS   = 12;
    localparam int ADDR_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        RD   = 3'd2,
        WSU  = 3'd3,
        WR   = 3'd4,
        RSP  = 3'd5
    } state_t;

    typedef struct packed {
        logic              r0_en;
        logic              r1_en;
        logic              w_en;
        logic [ADDR_W-1:0] r0_addr;
        logic [ADDR_W-1:0] r1_addr;
        logic [ADDR_W-1:0] w_addr;
        logic [COLS-1:0]   w_data;
    } req_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/toysram_wl_dec.sv
// 4-to-16 one-hot wordline decoder; all lines stay low when en is low.
module toysram_wl_dec
    import toysram_pkg::*;
(
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [ROWS-1:0]   wl
);

    always_comb begin
        wl = '0;
        if (en) begin
            wl[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/toysram_16x12_seq.sv
// Access sequencer for the 16x12 2R1W 10T subarray: phases precharge, read, write-setup
// and write wordlines, captures the read bitlines and returns one response pulse.
module toysram_16x12_seq
    import toysram_pkg::*;
#(
    parameter int PRE_CYC        = 1,
    parameter int RWL_CYC        = 2,
    parameter int WWL_CYC        = 2,
    parameter int RBL_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_r0_en,
    input  logic              req_r1_en,
    input  logic              req_w_en,
    input  logic [ADDR_W-1:0] req_r0_addr,
    input  logic [ADDR_W-1:0] req_r1_addr,
    input  logic [ADDR_W-1:0] req_w_addr,
    input  logic [COLS-1:0]   req_w_data,
    output logic              rsp_valid,
    output logic [COLS-1:0]   rsp_r0_data,
    output logic [COLS-1:0]   rsp_r1_data,
    output logic [ROWS-1:0]   rwl0,
    output logic [ROWS-1:0]   rwl1,
    output logic [ROWS-1:0]   wwl,
    output logic [COLS-1:0]   wbl,
    output logic [COLS-1:0]   wblb,
    output logic              rbl0_pre_n,
    output logic              rbl1_pre_n,
    input  logic [COLS-1:0]   rbl0,
    input  logic [COLS-1:0]   rbl1,
    output state_t            dbg_state
);

    localparam int MAX_CYC = max3(PRE_CYC, RWL_CYC, WWL_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_load;
    req_t             req_q, req_n;
    logic             accept, capture;
    logic [ROWS-1:0]  rwl0_d, rwl1_d, wwl_d;
    logic [COLS-1:0]  rd0_bits, rd1_bits;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready
    // is high only in IDLE and the request fields are only sampled on that transfer edge.
    assign accept    = req_valid && req_ready;
    assign capture   = (state == RD) && (cnt == '0);
    assign dbg_state = state;

    assign rd0_bits = (RBL_ACTIVE_LOW != 0) ? ~rbl0 : rbl0;
    assign rd1_bits = (RBL_ACTIVE_LOW != 0) ? ~rbl1 : rbl1;

    always_comb begin
        req_n = req_q;
        if (accept) begin
            req_n.r0_en   = req_r0_en;
            req_n.r1_en   = req_r1_en;
            req_n.w_en    = req_w_en;
            req_n.r0_addr = req_r0_addr;
            req_n.r1_addr = req_r1_addr;
            req_n.w_addr  = req_w_addr;
            req_n.w_data  = req_w_data;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_r0_en || req_r1_en) state_d = PRE;
                    else if (req_w_en)          state_d = WSU;
                    else                        state_d = RSP;
                end
            end
            PRE: if (cnt == '0) state_d = RD;
            RD:  if (cnt == '0) state_d = req_q.w_en ? WSU : RSP;
            WSU: state_d = WR;
            WR:  if (cnt == '0) state_d = RSP;
            RSP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The counter holds remaining cycles minus one, so a phase exits when it reads zero.
    always_comb begin
        cnt_load = '0;
        case (state_d)
            PRE:     cnt_load = CNT_W'(PRE_CYC - 1);
            RD:      cnt_load = CNT_W'(RWL_CYC - 1);
            WR:      cnt_load = CNT_W'(WWL_CYC - 1);
            default: cnt_load = '0;
        endcase
    end

    toysram_wl_dec u_dec_r0 (
        .en   (req_n.r0_en && (state_d == RD)),
        .addr (req_n.r0_addr),
        .wl   (rwl0_d)
    );

    toysram_wl_dec u_dec_r1 (
        .en   (req_n.r1_en && (state_d == RD)),
        .addr (req_n.r1_addr),
        .wl   (rwl1_d)
    );

    toysram_wl_dec u_dec_w (
        .en   (req_n.w_en && (state_d == WR)),
        .addr (req_n.w_addr),
        .wl   (wwl_d)
    );

    // Every array-facing output is registered from the next state, so it lines up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_q       <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_r0_data <= '0;
            rsp_r1_data <= '0;
            rwl0        <= '0;
            rwl1        <= '0;
            wwl         <= '0;
            wbl         <= '0;
            wblb        <= '0;
            rbl0_pre_n  <= 1'b0;
            rbl1_pre_n  <= 1'b0;
        end else begin
            state <= state_d;
            if (state_d != state) begin
                cnt <= cnt_load;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (accept) begin
                req_q <= req_n;
            end
            req_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == RSP);
            if (capture && req_q.r0_en) rsp_r0_data <= rd0_bits;
            if (capture && req_q.r1_en) rsp_r1_data <= rd1_bits;
            rwl0       <= rwl0_d;
            rwl1       <= rwl1_d;
            wwl        <= wwl_d;
            rbl0_pre_n <= (state_d == RD) && req_n.r0_en;
            rbl1_pre_n <= (state_d == RD) && req_n.r1_en;
            if ((state_d == WSU) || (state_d == WR)) begin
                wbl  <= req_n.w_data;
                wblb <= ~req_n.w_data;
            end else begin
                wbl  <= '0;
                wblb <= '0;
            end
        end
    end

endmodule
